// File: rtl/pipe_cla_pkg.sv
// Shared constants for the segmented carry-lookahead pipeline adder.
// Holds the default word/segment widths and the stage-count derivation.
package pipe_cla_pkg;

    localparam int DEF_BITS = 32;
    localparam int DEF_SEG  = 8;
    localparam int MIN_BITS = 8;
    localparam int MAX_BITS = 64;

    // One pipeline stage per SEG-bit slice of the operand word.
    function automatic int calc_stages(input int bits, input int seg);
        return bits / seg;
    endfunction

    function automatic bit cfg_legal(input int bits, input int seg);
        return (seg > 0) && ((bits % seg) == 0) && (bits >= MIN_BITS) && (bits <= MAX_BITS);
    endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational W-bit carry-lookahead adder slice: every internal carry is a
// flat generate/propagate product term of cin, and group P/G are exported.
module cla_seg #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         grp_p,
    output logic         grp_g
);

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;
    logic         run_p;
    logic         acc;

    assign p = a ^ b;
    assign g = a & b;

    // c[i] = G[i-1:0] | P[i-1:0] & cin, expanded as a sum of products per bit.
    always_comb begin
        c     = '0;
        run_p = 1'b1;
        acc   = 1'b0;
        grp_p = 1'b0;
        grp_g = 1'b0;
        c[0]  = cin;
        for (int i = 1; i <= W; i++) begin
            acc   = 1'b0;
            run_p = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                acc   = acc | (run_p & g[j]);
                run_p = run_p & p[j];
            end
            c[i] = acc | (run_p & cin);
        end
        grp_g = acc;
        grp_p = run_p;
    end

    assign sum  = p ^ c[W-1:0];
    assign cout = c[W];

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined adder/subtractor: stage k adds operand slice k with a lookahead
// slice and registers the carry. Define PIPE_CLA_OVF_EN to add the ovf output.
module pipe_cla_adder
    import pipe_cla_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int SEG  = DEF_SEG
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] sum,
    output logic            cout
`ifdef PIPE_CLA_OVF_EN
    ,
    output logic            ovf
`endif
);

    localparam int STAGES = calc_stages(BITS, SEG);

    if (!cfg_legal(BITS, SEG)) begin : g_bad_cfg
        $error("pipe_cla_adder: BITS must be a multiple of SEG within 8..64");
    end

    // Handshake: a word moves in on in_valid && in_ready and out on
    // out_valid && out_ready. The whole pipe advances as one when in_ready is
    // high and is frozen (data and valid bits) otherwise, so a stalled result
    // stays put and the slot it frees is refilled in the same cycle.
    logic advance;
    assign in_ready = !out_valid || out_ready;
    assign advance  = in_ready;

    // Idle cycles present zeros so X on the operand pins never enters the pipe.
    logic [BITS-1:0] a_in;
    logic [BITS-1:0] b_in;
    logic            c_in;

    assign a_in = in_valid ? a : '0;
    assign b_in = in_valid ? (sub ? ~b : b) : '0;
    assign c_in = in_valid & (sub | cin);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // REM = operand bits not yet consumed when entering this stage.
        localparam int REM = BITS - k * SEG;

        logic [REM-1:0]       a_src;
        logic [REM-1:0]       b_src;
        logic                 c_src;
        logic                 v_src;
        logic [(k+1)*SEG-1:0] s_next;
        logic [(k+1)*SEG-1:0] s_q;
        logic [SEG-1:0]       seg_sum;
        logic                 seg_cout;
        logic                 seg_p;
        logic                 seg_g;
        logic                 c_q;
        logic                 v_q;
        logic                 unused_cout;

        if (k == 0) begin : g_first
            assign a_src  = a_in;
            assign b_src  = b_in;
            assign c_src  = c_in;
            assign v_src  = in_valid;
            assign s_next = seg_sum;
        end else begin : g_next
            assign a_src  = g_stage[k-1].g_fwd.a_q;
            assign b_src  = g_stage[k-1].g_fwd.b_q;
            assign c_src  = g_stage[k-1].c_q;
            assign v_src  = g_stage[k-1].v_q;
            // Lower slices ride along below the new slice so the word leaves aligned.
            assign s_next = {seg_sum, g_stage[k-1].s_q};
        end

        cla_seg #(
            .W (SEG)
        ) u_seg (
            .a     (a_src[SEG-1:0]),
            .b     (b_src[SEG-1:0]),
            .cin   (c_src),
            .sum   (seg_sum),
            .cout  (seg_cout),
            .grp_p (seg_p),
            .grp_g (seg_g)
        );

        // The carry out is also available as seg_cout; the registered carry
        // uses the group terms so the slice-to-slice path stays two levels.
        assign unused_cout = seg_cout;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= v_src;
                c_q <= seg_g | (seg_p & c_src);
                s_q <= s_next;
            end
        end

        // Higher slices wait in skew registers until their stage is reached.
        if (REM > SEG) begin : g_fwd
            logic [REM-SEG-1:0] a_q;
            logic [REM-SEG-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_src[REM-1:SEG];
                    b_q <= b_src[REM-1:SEG];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;

`ifdef PIPE_CLA_OVF_EN
    // Signed overflow = carry into the MSB xor carry out of the MSB; the carry
    // into the MSB is recovered from the MSB's own sum bit.
    logic ovf_next;
    logic ovf_q;

    assign ovf_next = g_stage[STAGES-1].a_src[SEG-1] ^ g_stage[STAGES-1].b_src[SEG-1]
                    ^ g_stage[STAGES-1].seg_sum[SEG-1] ^ g_stage[STAGES-1].seg_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_next;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter BITS, default 32, operand/sum width; legal values are multiples of SEG, 8..64.
REQ-002 SHALL have parameter SEG, default 8, segment width per pipeline stage; STAGES = BITS/SEG.
REQ-003 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have in_valid  input  1  operands valid.
REQ-006 SHALL have in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have a / b  input  BITS  augend / addend.
REQ-008 SHALL have cin  input  1  carry in (ignored when sub=1).
REQ-009 SHALL have sub  input  1  1 = compute a - b.
REQ-010 SHALL have out_valid  input-to-output  output  1  result valid.
REQ-011 SHALL have out_ready  input  1  downstream accepts result.
REQ-012 SHALL have sum  output  BITS  result.
REQ-013 SHALL have cout  output  1  carry out of MSB (for sub: 1 = no borrow).

Function
REQ-014 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-015 SHALL process segment k (bits k*SEG .. k*SEG+SEG-1) in stage k, with the carry registered between stages.
REQ-016 SHALL skew-register higher-segment operands and deskew-register lower-segment sums so each result word leaves aligned.
REQ-017 SHALL have a latency of exactly STAGES cycles from acceptance to out_valid when not stalled.
REQ-018 SHALL compute the sum within a segment with group propagate/generate lookahead, not ripple.
REQ-019 SHALL compute a + ~b + 1 when sub=1, and a + b + cin when sub=0; results are modulo 2^BITS.
REQ-020 SHALL sustain one result per cycle when out_ready=1.
REQ-021 SHALL set in_ready = !out_valid || out_ready, and freeze all stages (valid bits included) when in_ready=0.
REQ-022 SHALL hold sum/cout/out_valid stable while out_valid && !out_ready.
REQ-023 SHALL accept a new operand in the cycle the final result is consumed (full pipe, simultaneous in/out).
REQ-024 SHALL propagate a bubble when in_valid=0 and the pipe advances; empty stages carry valid=0.
REQ-025 SHALL not depend on X on a/b/cin/sub when in_valid=0.

Reset
REQ-026 SHALL clear all stage valid bits, out_valid, sum and cout to 0 on rst_n low, immediately.
REQ-027 SHALL drop in-flight operations on reset mid-operation; no result appears after release.
REQ-028 SHALL make in_ready 1 in the first cycle after reset release.

Configuration
REQ-029 SHALL provide macro PIPE_CLA_OVF_EN; when defined, output ovf (1 bit) indicates signed two's-complement overflow of the same result, aligned with sum, reset 0.
REQ-030 SHALL have no ovf port and no extra registers when PIPE_CLA_OVF_EN is undefined; all other behaviour is identical.

Structure
REQ-031 SHALL keep the default BITS/SEG constants and the STAGES derivation function in shared package pipe_cla_pkg.
REQ-032 SHALL implement one combinational sub-module, cla_seg (SEG-bit lookahead adder: a, b, cin -> sum, cout, group P, G), instantiated STAGES times.
REQ-033 SHALL flag a non-multiple BITS/SEG as an elaboration error.

Verification (BITS=32, SEG=8, latency 4)
REQ-034 SHALL cover: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> after 4 cycles sum=0x00000000, cout=1 (carry across all segments).
REQ-035 SHALL cover: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0; with OVF_EN, a=0x7FFFFFFF, b=1, sub=0 -> ovf=1.
REQ-036 SHALL cover: 100 back-to-back random ops with out_ready=1 -> one result per cycle, in order, matching a 33-bit reference model.
REQ-037 SHALL cover: out_ready held 0 for 6 cycles with a full pipe -> in_ready=0, sum stable, no loss or duplication after release.
REQ-038 SHALL cover: rst_n pulsed low with 3 ops in flight -> out_valid=0 immediately, and no stale results afterwards.
